rom_load_ctrl: RTL and testbench

Sits directly downstream of the Avalon-facing ROM programmer. It turns that block's level-style `PRG_ROM_WRITE`/`CHR_ROM_WRITE` strobes into single-cycle write pulses into the on-chip PRG (32 KiB) and CHR (8 KiB) game memories. It range-checks every address and counts accepted bytes. It holds the NES core in reset until both images are fully loaded, plus a fixed settle time.

---
 rtl/rom_load_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctrl.sv
// Turns the programmer's level write strobes into single-cycle PRG/CHR memory writes,
// range-checks and counts bytes, and holds the NES core in reset until both images are loaded.
module rom_load_ctrl #(
  parameter int PRG_AW   = 15,
  parameter int CHR_AW   = 13,
  parameter int RST_HOLD = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [15:0]       ROM_ADDR,
  input  logic [7:0]        ROM_DATA,
  input  logic              PRG_ROM_WRITE,
  input  logic              CHR_ROM_WRITE,
  output logic              PRG_WE,
  output logic [PRG_AW-1:0] PRG_WADDR,
  output logic              CHR_WE,
  output logic [CHR_AW-1:0] CHR_WADDR,
  output logic [7:0]        WDATA,
  output logic              NES_RESET_N,
  output logic              LOADING,
  output logic              DONE,
  output logic              ADDR_ERR
);

  localparam int TW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [TW-1:0]   HOLD_LAST = TW'(RST_HOLD - 1);
  localparam logic [PRG_AW:0] PRG_FULL  = {1'b1, {PRG_AW{1'b0}}};
  localparam logic [CHR_AW:0] CHR_FULL  = {1'b1, {CHR_AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t            state_r;
  logic [TW-1:0]     timer_r;
  logic              prg_q_r;
  logic              chr_q_r;
  logic [PRG_AW:0]   prg_cnt_r;
  logic [CHR_AW:0]   chr_cnt_r;

  logic              prg_rise_s;
  logic              chr_rise_s;
  logic              prg_acc_s;
  logic              chr_acc_s;
  logic              any_acc_s;
  logic              wr_err_s;
  logic              prg_full_s;
  logic              chr_full_s;
  logic              reload_s;
  logic [PRG_AW:0]   prg_cnt_n_s;
  logic [CHR_AW:0]   chr_cnt_n_s;

  // Strobe edge detect, accept/reject decode and next counter values
  always_comb begin
    prg_rise_s  = PRG_ROM_WRITE & ~prg_q_r;
    chr_rise_s  = CHR_ROM_WRITE & ~chr_q_r;
    // A simultaneous PRG+CHR rise is ambiguous, so neither side is accepted
    prg_acc_s   = prg_rise_s & ~chr_rise_s & ((ROM_ADDR >> PRG_AW) == 16'd0);
    chr_acc_s   = chr_rise_s & ~prg_rise_s & ((ROM_ADDR >> CHR_AW) == 16'd0);
    any_acc_s   = prg_acc_s | chr_acc_s;
    wr_err_s    = (prg_rise_s | chr_rise_s) & ~any_acc_s;
    prg_full_s  = (prg_cnt_r == PRG_FULL);
    chr_full_s  = (chr_cnt_r == CHR_FULL);
    reload_s    = any_acc_s & ((state_r == ST_HOLD) | (state_r == ST_RUN));
    prg_cnt_n_s = prg_cnt_r;
    chr_cnt_n_s = chr_cnt_r;
    if (reload_s) begin
      prg_cnt_n_s = {{PRG_AW{1'b0}}, prg_acc_s};
      chr_cnt_n_s = {{CHR_AW{1'b0}}, chr_acc_s};
    end else begin
      if (prg_acc_s && !prg_full_s) begin
        prg_cnt_n_s = prg_cnt_r + {{PRG_AW{1'b0}}, 1'b1};
      end else begin
        prg_cnt_n_s = prg_cnt_r;
      end
      if (chr_acc_s && !chr_full_s) begin
        chr_cnt_n_s = chr_cnt_r + {{CHR_AW{1'b0}}, 1'b1};
      end else begin
        chr_cnt_n_s = chr_cnt_r;
      end
    end
  end

  // Write pulse generation, address/data capture, byte counters and sticky error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prg_q_r   <= 1'b0;
      chr_q_r   <= 1'b0;
      PRG_WE    <= 1'b0;
      CHR_WE    <= 1'b0;
      PRG_WADDR <= {PRG_AW{1'b0}};
      CHR_WADDR <= {CHR_AW{1'b0}};
      WDATA     <= 8'h00;
      prg_cnt_r <= {(PRG_AW + 1){1'b0}};
      chr_cnt_r <= {(CHR_AW + 1){1'b0}};
      ADDR_ERR  <= 1'b0;
    end else begin
      prg_q_r   <= PRG_ROM_WRITE;
      chr_q_r   <= CHR_ROM_WRITE;
      PRG_WE    <= prg_acc_s;
      CHR_WE    <= chr_acc_s;
      prg_cnt_r <= prg_cnt_n_s;
      chr_cnt_r <= chr_cnt_n_s;
      if (prg_acc_s) begin
        PRG_WADDR <= ROM_ADDR[PRG_AW-1:0];
        WDATA     <= ROM_DATA;
      end
      if (chr_acc_s) begin
        CHR_WADDR <= ROM_ADDR[CHR_AW-1:0];
        WDATA     <= ROM_DATA;
      end
      if (wr_err_s) begin
        ADDR_ERR <= 1'b1;
      end
    end
  end

  // Load sequencing FSM with registered status outputs and post-load reset hold timer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= ST_IDLE;
      timer_r     <= {TW{1'b0}};
      LOADING     <= 1'b0;
      DONE        <= 1'b0;
      NES_RESET_N <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_acc_s) begin
            state_r <= ST_LOAD;
            LOADING <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (prg_full_s && chr_full_s) begin
            state_r <= ST_HOLD;
            timer_r <= {TW{1'b0}};
            LOADING <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (any_acc_s) begin
            state_r <= ST_LOAD;
            LOADING <= 1'b1;
          end else if (timer_r == HOLD_LAST) begin
            state_r     <= ST_RUN;
            DONE        <= 1'b1;
            NES_RESET_N <= 1'b1;
          end else begin
            timer_r <= timer_r + {{(TW - 1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (any_acc_s) begin
            state_r     <= ST_LOAD;
            LOADING     <= 1'b1;
            DONE        <= 1'b0;
            NES_RESET_N <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          timer_r     <= {TW{1'b0}};
          LOADING     <= 1'b0;
          DONE        <= 1'b0;
          NES_RESET_N <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized self-checking bench for rom_load_ctrl against a byte-count / edge-time reference model.
module tb_rom_load_ctrl;
  localparam int PAW = 11;
  localparam int CAW = 9;
  localparam int RH  = 5;
  localparam int PSZ = 1 << PAW;
  localparam int CSZ = 1 << CAW;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic [15:0]    ROM_ADDR = 16'h0000;
  logic [7:0]     ROM_DATA = 8'h00;
  logic           PRG_ROM_WRITE = 1'b0;
  logic           CHR_ROM_WRITE = 1'b0;
  logic           PRG_WE;
  logic [PAW-1:0] PRG_WADDR;
  logic           CHR_WE;
  logic [CAW-1:0] CHR_WADDR;
  logic [7:0]     WDATA;
  logic           NES_RESET_N;
  logic           LOADING;
  logic           DONE;
  logic           ADDR_ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: byte counts, edge index at which both images became complete, sticky error
  int             m_prg;
  int             m_chr;
  int             m_done_edge;
  bit             m_started;
  bit             m_err;
  logic [PAW-1:0] m_paddr;
  logic [CAW-1:0] m_caddr;
  logic [7:0]     m_wdata;

  rom_load_ctrl #(.PRG_AW(PAW), .CHR_AW(CAW), .RST_HOLD(RH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .PRG_ROM_WRITE(PRG_ROM_WRITE), .CHR_ROM_WRITE(CHR_ROM_WRITE),
    .PRG_WE(PRG_WE), .PRG_WADDR(PRG_WADDR), .CHR_WE(CHR_WE), .CHR_WADDR(CHR_WADDR),
    .WDATA(WDATA), .NES_RESET_N(NES_RESET_N), .LOADING(LOADING), .DONE(DONE),
    .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected {LOADING, DONE, NES_RESET_N, ADDR_ERR} after edge e
  function automatic logic [3:0] exp_status(input int e);
    logic l;
    logic d;
    l = 1'b0;
    d = 1'b0;
    if (m_started) begin
      if (m_done_edge < 0) l = 1'b1;
      else begin
        l = (e - m_done_edge) < 1;
        d = (e - m_done_edge) >= RH + 1;
      end
    end
    return {l, d, d, m_err};
  endfunction

  task automatic model_clear();
    m_prg = 0; m_chr = 0; m_done_edge = -1; m_started = 0; m_err = 0;
    m_paddr = '0; m_caddr = '0; m_wdata = 8'h00;
  endtask

  // p/c are rising edges seen at the current edge; returns the expected write enables
  task automatic model_write(input bit p, input bit c, input logic [15:0] a, input logic [7:0] d,
                             output bit pwe, output bit cwe);
    int  e;
    bit  pok;
    bit  cok;
    e = cyc;
    pwe = 0;
    cwe = 0;
    pok = p && !c && (int'(a) < PSZ);
    cok = c && !p && (int'(a) < CSZ);
    if ((p || c) && !pok && !cok) m_err = 1;
    else if (pok || cok) begin
      if (m_done_edge >= 0 && (e - m_done_edge) >= 2) begin
        m_prg = 0;
        m_chr = 0;
        m_done_edge = -1;
      end
      m_started = 1;
      m_wdata = d;
      if (pok) begin
        pwe = 1;
        m_paddr = a[PAW-1:0];
        if (m_prg < PSZ) m_prg++;
      end else begin
        cwe = 1;
        m_caddr = a[CAW-1:0];
        if (m_chr < CSZ) m_chr++;
      end
      if (m_done_edge < 0 && m_prg == PSZ && m_chr == CSZ) m_done_edge = e;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    model_clear();
    repeat (3) tick();
    total++;
    if ({PRG_WE, CHR_WE, PRG_WADDR, CHR_WADDR, WDATA, NES_RESET_N, LOADING, DONE, ADDR_ERR} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b%b pa=%h ca=%h wd=%h nes=%b ld=%b dn=%b er=%b, want all 0",
               PRG_WE, CHR_WE, PRG_WADDR, CHR_WADDR, WDATA, NES_RESET_N, LOADING, DONE, ADDR_ERR);
    end
    total++;
    if ({dut.prg_cnt_r, dut.chr_cnt_r} !== '0) begin
      bad++;
      $display("FAIL reset_counters: got prg=%0d chr=%0d want 0 0", dut.prg_cnt_r, dut.chr_cnt_r);
    end
    #2 RESET_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR} !== {2'b00, exp_status(cyc)}) begin
        bad++;
        $display("FAIL idle_hold: cycle %0d got %b want %b", i,
                 {PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR}, {2'b00, exp_status(cyc)});
      end
    end
  endtask

  task automatic test_single_prg();
    bit pwe, cwe;
    PRG_ROM_WRITE = 1'b1;
    ROM_ADDR = 16'h0234;
    ROM_DATA = 8'hA5;
    for (int h = 0; h < 6; h++) begin
      if (h == 5) PRG_ROM_WRITE = 1'b0;
      tick();
      if (h == 0) model_write(1, 0, ROM_ADDR, ROM_DATA, pwe, cwe);
      else begin pwe = 0; cwe = 0; end
      ROM_DATA = 8'($urandom);
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR, PRG_WADDR, WDATA} !==
          {pwe, cwe, exp_status(cyc), m_paddr, m_wdata}) begin
        bad++;
        $display("FAIL single_prg: step %0d got we=%b%b st=%b pa=%h wd=%h want we=%b%b st=%b pa=%h wd=%h",
                 h, PRG_WE, CHR_WE, {LOADING, DONE, NES_RESET_N, ADDR_ERR}, PRG_WADDR, WDATA,
                 pwe, cwe, exp_status(cyc), m_paddr, m_wdata);
      end
    end
    total++;
    if ({PRG_WADDR, WDATA, LOADING} !== {11'h234, 8'hA5, 1'b1}) begin
      bad++;
      $display("FAIL single_prg_values: got pa=%h wd=%h ld=%b want 234 a5 1", PRG_WADDR, WDATA, LOADING);
    end
  endtask

  task automatic test_back_to_back();
    bit pwe, cwe;
    for (int i = 0; i < 8; i++) begin
      PRG_ROM_WRITE = (i % 2 == 0);
      if (i % 2 == 0) begin
        ROM_ADDR = 16'($urandom_range(0, PSZ - 1));
        ROM_DATA = 8'($urandom);
      end
      tick();
      if (i % 2 == 0) model_write(1, 0, ROM_ADDR, ROM_DATA, pwe, cwe);
      else begin pwe = 0; cwe = 0; end
      total++;
      if ({PRG_WE, CHR_WE, PRG_WADDR, WDATA} !== {pwe, cwe, m_paddr, m_wdata} ||
          dut.prg_cnt_r !== (PAW + 1)'(m_prg)) begin
        bad++;
        $display("FAIL back_to_back: step %0d got we=%b%b pa=%h wd=%h cnt=%0d want we=%b%b pa=%h wd=%h cnt=%0d",
                 i, PRG_WE, CHR_WE, PRG_WADDR, WDATA, dut.prg_cnt_r, pwe, cwe, m_paddr, m_wdata, m_prg);
      end
    end
  endtask

  task automatic test_addr_err();
    bit          pwe, cwe;
    bit          tp [6] = '{0, 1, 1, 0, 1, 1};
    bit          tc [6] = '{1, 0, 1, 1, 0, 1};
    logic [15:0] ta [6];
    ta = '{16'(CSZ), 16'(PSZ), 16'h0000, 16'(CSZ - 1), 16'(PSZ - 1), 16'h0005};
    for (int i = 0; i < 6; i++) begin
      PRG_ROM_WRITE = tp[i];
      CHR_ROM_WRITE = tc[i];
      ROM_ADDR = ta[i];
      ROM_DATA = 8'($urandom);
      tick();
      model_write(tp[i], tc[i], ROM_ADDR, ROM_DATA, pwe, cwe);
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR, PRG_WADDR, CHR_WADDR, WDATA} !==
          {pwe, cwe, exp_status(cyc), m_paddr, m_caddr, m_wdata} ||
          {dut.prg_cnt_r, dut.chr_cnt_r} !== {(PAW + 1)'(m_prg), (CAW + 1)'(m_chr)}) begin
        bad++;
        $display("FAIL addr_err: case %0d got we=%b%b st=%b cnt=%0d/%0d want we=%b%b st=%b cnt=%0d/%0d",
                 i, PRG_WE, CHR_WE, {LOADING, DONE, NES_RESET_N, ADDR_ERR}, dut.prg_cnt_r,
                 dut.chr_cnt_r, pwe, cwe, exp_status(cyc), m_prg, m_chr);
      end
      PRG_ROM_WRITE = 1'b0;
      CHR_ROM_WRITE = 1'b0;
      tick();
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR} !== {2'b00, exp_status(cyc)}) begin
        bad++;
        $display("FAIL addr_err_idle: case %0d got %b want %b", i,
                 {PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR}, {2'b00, exp_status(cyc)});
      end
    end
  endtask

  task automatic test_full_load();
    bit pwe, cwe;
    int pi = 0;
    int ci = 0;
    while (m_chr < CSZ || m_prg < PSZ) begin
      for (int s = 0; s < 2; s++) begin
        PRG_ROM_WRITE = (s == 0) && (m_prg < PSZ);
        CHR_ROM_WRITE = (s == 1) && (m_chr < CSZ);
        if (PRG_ROM_WRITE) begin ROM_ADDR = 16'(pi % PSZ); pi++; end
        else if (CHR_ROM_WRITE) begin ROM_ADDR = 16'(ci % CSZ); ci++; end
        ROM_DATA = 8'($urandom);
        tick();
        model_write(PRG_ROM_WRITE, CHR_ROM_WRITE, ROM_ADDR, ROM_DATA, pwe, cwe);
        total++;
        if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR, PRG_WADDR, CHR_WADDR, WDATA} !==
            {pwe, cwe, exp_status(cyc), m_paddr, m_caddr, m_wdata}) begin
          bad++;
          $display("FAIL full_load: prg=%0d chr=%0d got we=%b%b st=%b pa=%h ca=%h want we=%b%b st=%b pa=%h ca=%h",
                   m_prg, m_chr, PRG_WE, CHR_WE, {LOADING, DONE, NES_RESET_N, ADDR_ERR}, PRG_WADDR,
                   CHR_WADDR, pwe, cwe, exp_status(cyc), m_paddr, m_caddr);
        end
      end
    end
    PRG_ROM_WRITE = 1'b0;
    CHR_ROM_WRITE = 1'b0;
    for (int i = 0; i < RH + 4; i++) begin
      tick();
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR} !== {2'b00, exp_status(cyc)}) begin
        bad++;
        $display("FAIL hold_timing: %0d cycles after last WE got %b want %b", i + 1,
                 {PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR}, {2'b00, exp_status(cyc)});
      end
    end
    total++;
    if ({DONE, NES_RESET_N, LOADING} !== 3'b110) begin
      bad++;
      $display("FAIL run_state: got dn=%b nes=%b ld=%b want 1 1 0", DONE, NES_RESET_N, LOADING);
    end
  endtask

  task automatic test_reload();
    bit pwe, cwe;
    PRG_ROM_WRITE = 1'b1;
    ROM_ADDR = 16'h0000;
    ROM_DATA = 8'h3C;
    tick();
    model_write(1, 0, ROM_ADDR, ROM_DATA, pwe, cwe);
    PRG_ROM_WRITE = 1'b0;
    total++;
    if ({PRG_WE, LOADING, DONE, NES_RESET_N} !== {pwe, exp_status(cyc)[3:1]} ||
        {dut.prg_cnt_r, dut.chr_cnt_r} !== {(PAW + 1)'(m_prg), (CAW + 1)'(m_chr)}) begin
      bad++;
      $display("FAIL reload: got we=%b ld=%b dn=%b nes=%b cnt=%0d/%0d want we=%b st=%b cnt=%0d/%0d",
               PRG_WE, LOADING, DONE, NES_RESET_N, dut.prg_cnt_r, dut.chr_cnt_r,
               pwe, exp_status(cyc), m_prg, m_chr);
    end
    tick();
  endtask

  task automatic test_random();
    bit pwe, cwe;
    for (int op = 0; op < 200; op++) begin
      int          kind;
      int          hold;
      int          gap;
      bit          p;
      bit          c;
      logic [15:0] a;
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 2);
      p = (kind <= 4);
      c = (kind == 0) || (kind >= 5 && kind <= 8);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(p ? PSZ : CSZ, 65535));
      else a = 16'($urandom_range(0, (p && !c) ? PSZ - 1 : CSZ - 1));
      PRG_ROM_WRITE = p;
      CHR_ROM_WRITE = c;
      ROM_ADDR = a;
      ROM_DATA = 8'($urandom);
      for (int t = 0; t < hold + gap; t++) begin
        if (t == hold) begin
          PRG_ROM_WRITE = 1'b0;
          CHR_ROM_WRITE = 1'b0;
        end
        tick();
        if (t == 0) model_write(p, c, ROM_ADDR, ROM_DATA, pwe, cwe);
        else begin pwe = 0; cwe = 0; end
        if (t >= hold) ROM_ADDR = 16'($urandom);
        total++;
        if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR, PRG_WADDR, CHR_WADDR, WDATA} !==
            {pwe, cwe, exp_status(cyc), m_paddr, m_caddr, m_wdata} ||
            {dut.prg_cnt_r, dut.chr_cnt_r} !== {(PAW + 1)'(m_prg), (CAW + 1)'(m_chr)}) begin
          bad++;
          $display("FAIL random: op %0d t %0d got we=%b%b st=%b pa=%h ca=%h wd=%h cnt=%0d/%0d want we=%b%b st=%b pa=%h ca=%h wd=%h cnt=%0d/%0d",
                   op, t, PRG_WE, CHR_WE, {LOADING, DONE, NES_RESET_N, ADDR_ERR}, PRG_WADDR, CHR_WADDR,
                   WDATA, dut.prg_cnt_r, dut.chr_cnt_r, pwe, cwe, exp_status(cyc), m_paddr, m_caddr,
                   m_wdata, m_prg, m_chr);
        end
      end
    end
  endtask

  task automatic test_midload_reset();
    bit pwe, cwe;
    for (int i = 0; i < 1000; i++) begin
      PRG_ROM_WRITE = (i % 2 == 0);
      CHR_ROM_WRITE = (i % 2 == 1);
      ROM_ADDR = 16'($urandom_range(0, CSZ - 1));
      ROM_DATA = 8'($urandom);
      tick();
      model_write(PRG_ROM_WRITE, CHR_ROM_WRITE, ROM_ADDR, ROM_DATA, pwe, cwe);
      total++;
      if ({PRG_WE, CHR_WE, LOADING} !== {pwe, cwe, exp_status(cyc)[3]}) begin
        bad++;
        $display("FAIL midload_write: %0d got we=%b%b ld=%b want we=%b%b ld=%b",
                 i, PRG_WE, CHR_WE, LOADING, pwe, cwe, exp_status(cyc)[3]);
      end
    end
    #2 RESET_N = 1'b0;
    PRG_ROM_WRITE = 1'b0;
    CHR_ROM_WRITE = 1'b0;
    model_clear();
    #1;
    total++;
    if ({PRG_WE, CHR_WE, PRG_WADDR, CHR_WADDR, WDATA, NES_RESET_N, LOADING, DONE, ADDR_ERR} !== '0) begin
      bad++;
      $display("FAIL async_reset: got we=%b%b pa=%h ca=%h wd=%h nes=%b ld=%b dn=%b er=%b, want all 0",
               PRG_WE, CHR_WE, PRG_WADDR, CHR_WADDR, WDATA, NES_RESET_N, LOADING, DONE, ADDR_ERR);
    end
    #3 RESET_N = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if ({PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR} !== {2'b00, exp_status(cyc)} ||
          {dut.prg_cnt_r, dut.chr_cnt_r} !== '0) begin
        bad++;
        $display("FAIL post_reset_idle: got %b cnt=%0d/%0d want %b cnt=0/0",
                 {PRG_WE, CHR_WE, LOADING, DONE, NES_RESET_N, ADDR_ERR}, dut.prg_cnt_r, dut.chr_cnt_r,
                 {2'b00, exp_status(cyc)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_prg();
    test_back_to_back();
    test_addr_err();
    test_full_load();
    test_reload();
    test_random();
    test_midload_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
